// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 Hz timing constants and coordinate type.
// Used by the timing pipe, the renderer and the mouse overlay.
package vga_pkg;

    typedef logic [9:0] coord_t;

    // Horizontal timing in pixel clocks
    localparam coord_t H_ACTIVE = 10'd640;
    localparam coord_t H_FP     = 10'd16;
    localparam coord_t H_SYNC   = 10'd96;
    localparam coord_t H_BP     = 10'd48;
    localparam coord_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800

    // Vertical timing in lines
    localparam coord_t V_ACTIVE = 10'd480;
    localparam coord_t V_FP     = 10'd10;
    localparam coord_t V_SYNC   = 10'd2;
    localparam coord_t V_BP     = 10'd33;
    localparam coord_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

    // Inclusive sync windows on the undelayed counters
    localparam coord_t H_SYNC_START = H_ACTIVE + H_FP;               // 656
    localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1; // 751
    localparam coord_t V_SYNC_START = V_ACTIVE + V_FP;               // 490
    localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1; // 491

    localparam coord_t H_LAST = H_TOTAL - 10'd1;
    localparam coord_t V_LAST = V_TOTAL - 10'd1;

    localparam int unsigned TAP_DEPTH    = 6;
    localparam int unsigned SYNC_DELAY   = 1;
    localparam int unsigned COORD_PAIR_W = 20;

    function automatic logic in_span(input coord_t c, input coord_t lo, input coord_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/coord_delay_line.sv
// Shift register of packed {v,h} coordinate pairs with every stage exposed.
//   clk_i   pixel clock
//   rst_i   asynchronous active-high reset, clears all stages to 0
//   d_i     coordinate pair entering stage 0
//   taps_o  taps_o[k] is d_i delayed by k+1 cycles
module coord_delay_line #(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned WIDTH = 20
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [WIDTH-1:0]            d_i,
    output logic [DEPTH-1:0][WIDTH-1:0] taps_o
);

    logic [DEPTH-1:0][WIDTH-1:0] taps_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            taps_q <= '0;
        end else begin
            taps_q <= {taps_q[DEPTH-2:0], d_i};
        end
    end

    assign taps_o = taps_q;

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA 640x480@60 Hz timing generator with delayed coordinate taps for the
// renderer's ROM-fetch pipeline.
//   clk_25mhz_i           25 MHz pixel clock
//   rst_i                 asynchronous active-high reset
//   h_cnt_o / v_cnt_o     current column (0..799) / line (0..524)
//   h_cnt_k_o / v_cnt_k_o counters delayed by k cycles (k = 1..6)
//   valid_o               inside the 640x480 visible area, aligned with h/v_cnt
//   hsync_o / vsync_o     active-low syncs, SYNC_DELAY cycles behind h/v_cnt
//   frame_start_o         one-cycle pulse while (h_cnt, v_cnt) == (0, 0)
module vga_timing_pipe
    import vga_pkg::*;
(
    input  logic   clk_25mhz_i,
    input  logic   rst_i,
    output coord_t h_cnt_o,
    output coord_t v_cnt_o,
    output coord_t h_cnt_1_o,
    output coord_t h_cnt_2_o,
    output coord_t h_cnt_3_o,
    output coord_t h_cnt_4_o,
    output coord_t h_cnt_5_o,
    output coord_t h_cnt_6_o,
    output coord_t v_cnt_1_o,
    output coord_t v_cnt_2_o,
    output coord_t v_cnt_3_o,
    output coord_t v_cnt_4_o,
    output coord_t v_cnt_5_o,
    output coord_t v_cnt_6_o,
    output logic   valid_o,
    output logic   hsync_o,
    output logic   vsync_o,
    output logic   frame_start_o
);

    // run_q holds the counters at (0,0) for the first edge after reset so that
    // the first post-reset cycle presents pixel (0,0) with valid and frame_start.
    logic   run_q;
    coord_t h_q, h_d;
    coord_t v_q, v_d;
    logic   valid_q;
    logic   frame_start_q;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (run_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // valid/frame_start are computed from next-state counters so they line up
    // with h_q/v_q in the same cycle.
    always_ff @(posedge clk_25mhz_i or posedge rst_i) begin
        if (rst_i) begin
            run_q         <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            run_q         <= 1'b1;
            h_q           <= h_d;
            v_q           <= v_d;
            valid_q       <= (h_d < H_ACTIVE) && (v_d < V_ACTIVE);
            frame_start_q <= (h_d == '0) && (v_d == '0);
        end
    end

    // Sync delay: {vsync, hsync} per stage, idle-high.
    logic [1:0]                  sync_raw;
    logic [SYNC_DELAY-1:0][1:0]  sync_q;
    logic [SYNC_DELAY-1:0][1:0]  sync_shift;

    assign sync_raw = {~in_span(v_q, V_SYNC_START, V_SYNC_END),
                       ~in_span(h_q, H_SYNC_START, H_SYNC_END)};

    if (SYNC_DELAY > 1) begin : g_sync_multi
        assign sync_shift = {sync_q[SYNC_DELAY-2:0], sync_raw};
    end else begin : g_sync_single
        assign sync_shift = sync_raw;
    end

    always_ff @(posedge clk_25mhz_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_shift;
        end
    end

    // Coordinate taps
    logic [TAP_DEPTH-1:0][COORD_PAIR_W-1:0] taps;

    coord_delay_line #(
        .DEPTH (TAP_DEPTH),
        .WIDTH (COORD_PAIR_W)
    ) u_taps (
        .clk_i  (clk_25mhz_i),
        .rst_i  (rst_i),
        .d_i    ({v_q, h_q}),
        .taps_o (taps)
    );

    assign h_cnt_o       = h_q;
    assign v_cnt_o       = v_q;
    assign valid_o       = valid_q;
    assign frame_start_o = frame_start_q;
    assign hsync_o       = sync_q[SYNC_DELAY-1][0];
    assign vsync_o       = sync_q[SYNC_DELAY-1][1];

    assign h_cnt_1_o = taps[0][9:0];
    assign h_cnt_2_o = taps[1][9:0];
    assign h_cnt_3_o = taps[2][9:0];
    assign h_cnt_4_o = taps[3][9:0];
    assign h_cnt_5_o = taps[4][9:0];
    assign h_cnt_6_o = taps[5][9:0];
    assign v_cnt_1_o = taps[0][19:10];
    assign v_cnt_2_o = taps[1][19:10];
    assign v_cnt_3_o = taps[2][19:10];
    assign v_cnt_4_o = taps[3][19:10];
    assign v_cnt_5_o = taps[4][19:10];
    assign v_cnt_6_o = taps[5][19:10];

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: hand-computed vector table plus a cycle model of
// the counters, taps and syncs. Long vertical stretches are skipped by forcing
// the line counter for one clock at a point where the line does not wrap.
module tb_vga_timing_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] h, v, h1, h2, h3, h4, h5, h6, v1, v2, v3, v4, v5, v6;
    logic       valid, hs, vs, fs;
    logic [9:0] jump_v;

    always #20 clk = ~clk;

    vga_timing_pipe dut (
        .clk_25mhz_i   (clk),
        .rst_i         (rst),
        .h_cnt_o       (h),
        .v_cnt_o       (v),
        .h_cnt_1_o     (h1),
        .h_cnt_2_o     (h2),
        .h_cnt_3_o     (h3),
        .h_cnt_4_o     (h4),
        .h_cnt_5_o     (h5),
        .h_cnt_6_o     (h6),
        .v_cnt_1_o     (v1),
        .v_cnt_2_o     (v2),
        .v_cnt_3_o     (v3),
        .v_cnt_4_o     (v4),
        .v_cnt_5_o     (v5),
        .v_cnt_6_o     (v6),
        .valid_o       (valid),
        .hsync_o       (hs),
        .vsync_o       (vs),
        .frame_start_o (fs)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    int exp_h, exp_v, prev_h, prev_v;
    bit run;
    int hist_h[6];
    int hist_v[6];
    int hs_run, vs_run;

    typedef struct {
        bit jump;
        int h;
        int v;
        bit valid;
        bit hs;
        bit vs;
        bit fs;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d, expected %0d (model h=%0d v=%0d)",
                         name, act, exp, exp_h, exp_v);
        end
    endtask

    task automatic model_reset();
        exp_h = 0; exp_v = 0; prev_h = 0; prev_v = 0; run = 0;
        for (int k = 0; k < 6; k++) begin
            hist_h[k] = 0;
            hist_v[k] = 0;
        end
        hs_run = 0; vs_run = 0;
    endtask

    task automatic model_advance();
        for (int k = 5; k > 0; k--) begin
            hist_h[k] = hist_h[k-1];
            hist_v[k] = hist_v[k-1];
        end
        hist_h[0] = exp_h;
        hist_v[0] = exp_v;
        prev_h = exp_h;
        prev_v = exp_v;
        if (!run) begin
            exp_h = 0; exp_v = 0; run = 1;
        end else if (exp_h == 799) begin
            exp_h = 0;
            exp_v = (exp_v == 524) ? 0 : exp_v + 1;
        end else begin
            exp_h = exp_h + 1;
        end
    endtask

    task automatic check_all();
        int th[6];
        int tv[6];
        th[0] = h1; th[1] = h2; th[2] = h3; th[3] = h4; th[4] = h5; th[5] = h6;
        tv[0] = v1; tv[1] = v2; tv[2] = v3; tv[3] = v4; tv[4] = v5; tv[5] = v6;
        chk("h_cnt", h, exp_h);
        chk("v_cnt", v, exp_v);
        chk("valid", valid, int'(exp_h < 640 && exp_v < 480));
        chk("hsync", hs, int'(!(prev_h >= 656 && prev_h <= 751)));
        chk("vsync", vs, int'(!(prev_v >= 490 && prev_v <= 491)));
        chk("frame_start", fs, int'(exp_h == 0 && exp_v == 0));
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("h_cnt_%0d", k + 1), th[k], hist_h[k]);
            chk($sformatf("v_cnt_%0d", k + 1), tv[k], hist_v[k]);
        end
        if (hs == 1'b0) hs_run++;
        else if (hs_run != 0) begin
            chk("hsync_low_len", hs_run, 96);
            hs_run = 0;
        end
        if (vs == 1'b0) vs_run++;
        else if (vs_run != 0) begin
            chk("vsync_low_len", vs_run, 1600);
            vs_run = 0;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_h"}, h, 0);
        chk({tag, "_v"}, v, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_hsync"}, hs, 1);
        chk({tag, "_vsync"}, vs, 1);
        chk({tag, "_frame_start"}, fs, 0);
        chk({tag, "_htaps"}, {h1, h2, h3, h4, h5, h6}, 0);
        chk({tag, "_vtaps"}, {v1, v2, v3, v4, v5, v6}, 0);
    endtask

    task automatic step();
        @(negedge clk);
        model_advance();
        check_all();
    endtask

    task automatic step_to(input int th, input int tv);
        int n = 0;
        while (!(exp_h == th && exp_v == tv) && n < 30000) begin
            step();
            n++;
        end
        if (n >= 30000) begin
            checks++;
            errors++;
            $display("FAIL step_to: model never reached h=%0d v=%0d, expected to within 30000 cycles",
                     th, tv);
        end
    endtask

    // Jump the line counter at the current column (never at column 799).
    task automatic jump_to(input int nv);
        jump_v = 10'(nv);
        force dut.v_q = jump_v;
        exp_v = nv;
        step();
        release dut.v_q;
    endtask

    task automatic apply(input int i);
        if (tbl[i].jump) begin
            jump_to(tbl[i].v);
        end else begin
            step_to(tbl[i].h, tbl[i].v);
            chk($sformatf("vec%0d_h", i), h, tbl[i].h);
            chk($sformatf("vec%0d_v", i), v, tbl[i].v);
            chk($sformatf("vec%0d_valid", i), valid, tbl[i].valid);
            chk($sformatf("vec%0d_hsync", i), hs, tbl[i].hs);
            chk($sformatf("vec%0d_vsync", i), vs, tbl[i].vs);
            chk($sformatf("vec%0d_frame_start", i), fs, tbl[i].fs);
        end
    endtask

    initial begin
        //            jump  h    v   valid hs vs fs
        tbl[0]  = '{1'b0,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 639,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 640,   0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 656,   0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 657,   0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 751,   0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 752,   0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 753,   0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 799,   0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0,   0,   1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0,   3,  10, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b1,   0, 479, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0,   0, 480, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0,   0, 490, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b0,   1, 490, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 657, 490, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0,   0, 492, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b0,   1, 492, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[18] = '{1'b1,   0, 523, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[20] = '{1'b0,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[21] = '{1'b0,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[22] = '{1'b1,   0, 490, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 700, 490, 1'b0, 1'b0, 1'b0, 1'b0};

        model_reset();
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_reset("in_reset");
        end
        rst = 1'b0;

        // First cycle after release presents pixel (0,0)
        step();
        chk("first_h", h, 0);
        chk("first_v", v, 0);
        chk("first_valid", valid, 1);
        chk("first_frame_start", fs, 1);
        chk("first_hsync", hs, 1);
        chk("first_vsync", vs, 1);

        for (int i = 0; i <= 10; i++) apply(i);

        // Steady-state taps at (3,10)
        chk("tap_h1", h1, 2);
        chk("tap_h2", h2, 1);
        chk("tap_h3", h3, 0);
        chk("tap_h4", h4, 799);
        chk("tap_h5", h5, 798);
        chk("tap_h6", h6, 797);
        chk("tap_v1", v1, 10);
        chk("tap_v4", v4, 9);
        chk("tap_v5", v5, 9);
        chk("tap_v6", v6, 9);

        for (int i = 11; i <= 23; i++) apply(i);

        // Reset inside vsync and hsync at (700,490): outputs clear without a clock
        rst = 1'b1;
        #1;
        check_reset("async_rst");
        repeat (2) begin
            @(negedge clk);
            check_reset("mid_reset");
        end
        rst = 1'b0;
        model_reset();
        step();
        chk("restart_h", h, 0);
        chk("restart_v", v, 0);
        chk("restart_valid", valid, 1);
        chk("restart_frame_start", fs, 1);
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
